tdm_receiver: RTL and testbench

TDM_RECEIVER -- requirements
Module: tdm_receiver

---
 rtl/tdm_receiver.sv | 152 +++++++++++++++
 tb/tb_tdm_receiver.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_receiver.sv
// TDM serial ADC receiver: deserialises 24-bit slot samples from an asynchronous bit clock
// and presents them on an AXI-Stream master through a 4-entry FIFO.
module tdm_receiver #(
   parameter int unsigned SLOTS     = 8,
   parameter int unsigned SLOT_BITS = 32
) (
   input  logic        m_axis_aclk,
   input  logic        m_axis_areset,
   input  logic        tdm_bclk,
   input  logic        tdm_fsync,
   input  logic        tdm_sdata,
   input  logic        enable,
   input  logic        clear,
   output logic [23:0] m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic [2:0]  m_axis_tuser,
   output logic        m_axis_tlast,
   output logic        overflow,
   output logic        frame_err
);
   localparam int unsigned       CntW     = $clog2(SLOT_BITS);
   localparam logic [CntW-1:0]   LastBit  = CntW'(SLOT_BITS - 1);
   localparam logic [CntW-1:0]   MsbCnt   = CntW'(24);
   localparam logic [CntW-1:0]   LsbBit   = CntW'(23);
   localparam logic [2:0]        LastSlot = 3'(SLOTS - 1);

   typedef enum logic {StIdle, StRun} state_e;

   logic [1:0]      bclk_sync_q, fsync_sync_q, sdata_sync_q;
   logic            bclk_last_q;
   logic            bit_edge, fsync_s, sdata_s, at_frame_start, frame_set;
   state_e          state_q;
   logic [CntW-1:0] bit_q;
   logic [2:0]      slot_q;
   logic [23:0]     shift_q;
   logic            wr_q, wr_last_q;
   logic [23:0]     wr_data_q;
   logic [2:0]      wr_user_q;

   logic [27:0]     mem_q [4];
   logic [1:0]      wr_ptr_q, rd_ptr_q, rd_ptr_d;
   logic [2:0]      count_q, count_d;
   logic            full, push, pop, ovf_set;
   logic [27:0]     wr_word, head_d;

   always_ff @(posedge m_axis_aclk) begin
      if (m_axis_areset) begin
         bclk_sync_q  <= '0;
         fsync_sync_q <= '0;
         sdata_sync_q <= '0;
         bclk_last_q  <= 1'b0;
      end else begin
         bclk_sync_q  <= {bclk_sync_q[0], tdm_bclk};
         fsync_sync_q <= {fsync_sync_q[0], tdm_fsync};
         sdata_sync_q <= {sdata_sync_q[0], tdm_sdata};
         bclk_last_q  <= bclk_sync_q[1];
      end
   end

   assign bit_edge       = bclk_sync_q[1] & ~bclk_last_q;
   assign fsync_s        = fsync_sync_q[1];
   assign sdata_s        = sdata_sync_q[1];
   assign at_frame_start = (bit_q == '0) && (slot_q == '0);
   // fsync must coincide exactly with slot 0 bit 0 while running; either mismatch is an error
   assign frame_set      = bit_edge && enable && (state_q == StRun) && (fsync_s != at_frame_start);

   always_ff @(posedge m_axis_aclk) begin
      if (m_axis_areset) begin
         state_q   <= StIdle;
         bit_q     <= '0;
         slot_q    <= '0;
         shift_q   <= '0;
         wr_q      <= 1'b0;
         wr_data_q <= '0;
         wr_user_q <= '0;
         wr_last_q <= 1'b0;
      end else begin
         wr_q <= 1'b0;
         if (!enable) begin
            state_q <= StIdle;
            bit_q   <= '0;
            slot_q  <= '0;
         end else if (bit_edge) begin
            if (fsync_s && ((state_q == StIdle) || !at_frame_start)) begin
               state_q <= StRun;
               bit_q   <= CntW'(1);
               slot_q  <= '0;
               shift_q <= {23'd0, sdata_s};
            end else if (state_q == StRun) begin
               if (at_frame_start && !fsync_s) begin
                  state_q <= StIdle;
               end else begin
                  if (bit_q < MsbCnt) shift_q <= {shift_q[22:0], sdata_s};
                  if (bit_q == LsbBit) begin
                     wr_q      <= 1'b1;
                     wr_data_q <= {shift_q[22:0], sdata_s};
                     wr_user_q <= slot_q;
                     wr_last_q <= (slot_q == LastSlot);
                  end
                  if (bit_q == LastBit) begin
                     bit_q  <= '0;
                     slot_q <= (slot_q == LastSlot) ? 3'd0 : slot_q + 3'd1;
                  end else begin
                     bit_q <= bit_q + CntW'(1);
                  end
               end
            end
         end
      end
   end

   assign wr_word = {wr_last_q, wr_user_q, wr_data_q};

   // Output registers are loaded with the post-update head, bypassing a same-cycle write
   always_comb begin
      full     = (count_q == 3'd4);
      pop      = m_axis_tvalid & m_axis_tready;
      push     = wr_q & (~full | pop);
      ovf_set  = wr_q & full & ~pop;
      rd_ptr_d = rd_ptr_q + {1'b0, pop};
      count_d  = count_q + {2'b00, push} - {2'b00, pop};
      head_d   = (push && (wr_ptr_q == rd_ptr_d)) ? wr_word : mem_q[rd_ptr_d];
   end

   always_ff @(posedge m_axis_aclk) begin
      if (push) mem_q[wr_ptr_q] <= wr_word;
   end

   always_ff @(posedge m_axis_aclk) begin
      if (m_axis_areset) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tuser  <= '0;
         m_axis_tlast  <= 1'b0;
         overflow      <= 1'b0;
         frame_err     <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         m_axis_tvalid <= (count_d != 3'd0);
         if (count_d != 3'd0) {m_axis_tlast, m_axis_tuser, m_axis_tdata} <= head_d;
         overflow      <= ovf_set | (overflow & ~clear);
         frame_err     <= frame_set | (frame_err & ~clear);
      end
   end

endmodule

// File: tb/tb_tdm_receiver.sv
// Self-checking bench for tdm_receiver: random TDM frames against a slot-level sample model.
module tb_tdm_receiver;
   localparam int unsigned SLOTS     = 8;
   localparam int unsigned SLOT_BITS = 32;
   localparam int unsigned HALF_BCLK = 5;

   logic        m_axis_aclk   = 1'b0;
   logic        m_axis_areset = 1'b1;
   logic        tdm_bclk      = 1'b0;
   logic        tdm_fsync     = 1'b0;
   logic        tdm_sdata     = 1'b0;
   logic        enable        = 1'b1;
   logic        clear         = 1'b0;
   logic        m_axis_tready = 1'b0;
   logic [23:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic [2:0]  m_axis_tuser;
   logic        m_axis_tlast;
   logic        overflow;
   logic        frame_err;

   typedef struct packed {
      logic [23:0] data;
      logic [2:0]  user;
      logic        last;
   } sample_t;

   sample_t     got_q[$];
   sample_t     exp_q[$];
   logic [23:0] frame_d [SLOTS];
   logic [23:0] saved_d [SLOTS];
   int          checks   = 0;
   int          failures = 0;
   bit          stop_rand;

   tdm_receiver #(.SLOTS(SLOTS), .SLOT_BITS(SLOT_BITS)) dut (
      .m_axis_aclk  (m_axis_aclk),
      .m_axis_areset(m_axis_areset),
      .tdm_bclk     (tdm_bclk),
      .tdm_fsync    (tdm_fsync),
      .tdm_sdata    (tdm_sdata),
      .enable       (enable),
      .clear        (clear),
      .m_axis_tdata (m_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .m_axis_tuser (m_axis_tuser),
      .m_axis_tlast (m_axis_tlast),
      .overflow     (overflow),
      .frame_err    (frame_err)
   );

   always #5 m_axis_aclk = ~m_axis_aclk;

   // Transfers are recorded half a cycle before the edge that completes them
   always @(negedge m_axis_aclk)
      if (!m_axis_areset && m_axis_tvalid && m_axis_tready)
         got_q.push_back(sample_t'({m_axis_tdata, m_axis_tuser, m_axis_tlast}));

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge m_axis_aclk);
      #1;
   endtask

   task automatic send_bit(input logic fs, input logic sd);
      tdm_fsync = fs;
      tdm_sdata = sd;
      cycles(HALF_BCLK);
      tdm_bclk = 1'b1;
      cycles(HALF_BCLK);
      tdm_bclk = 1'b0;
   endtask

   task automatic send_slot_bits(input logic [23:0] word, input logic fs, input int lo,
                                 input int hi);
      for (int b = lo; b <= hi; b++)
         send_bit(fs && (b == 0), (b < 24) ? word[23-b] : 1'($urandom));
   endtask

   task automatic send_frame(input logic fs);
      for (int s = 0; s < SLOTS; s++) send_slot_bits(frame_d[s], fs && (s == 0), 0, SLOT_BITS - 1);
   endtask

   task automatic randomize_frame();
      for (int s = 0; s < SLOTS; s++) frame_d[s] = 24'($urandom);
   endtask

   // Model: each completed slot yields {data, slot index, last = final slot}
   task automatic expect_slots(input int lo, input int hi);
      for (int s = lo; s <= hi; s++)
         exp_q.push_back(sample_t'({frame_d[s], 3'(s), (s == SLOTS - 1)}));
   endtask

   task automatic start_test();
      got_q.delete();
      exp_q.delete();
      m_axis_tready = 1'b1;
      enable = 1'b1;
   endtask

   task automatic end_capture();
      enable = 1'b0;
      cycles(3);
      enable = 1'b1;
   endtask

   task automatic test_reset();
      m_axis_areset = 1'b1;
      cycles(4);
      checks++;
      if ({m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast} !== 29'd0) begin
         failures++;
         $display("FAIL reset_outputs: got valid=%b data=%h user=%0d last=%b, expected all 0",
                  m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast);
      end
      checks++;
      if ({overflow, frame_err} !== 2'b00) begin
         failures++;
         $display("FAIL reset_flags: got ovf=%b ferr=%b, expected 0 0", overflow, frame_err);
      end
      m_axis_areset = 1'b0;
      cycles(4);
   endtask

   task automatic test_basic();
      start_test();
      for (int s = 0; s < SLOTS; s++) frame_d[s] = 24'h100000 + 24'(s);
      expect_slots(0, SLOTS - 1);
      send_frame(1'b1);
      cycles(20);
      checks++;
      if (got_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL basic_count: got %0d samples, expected %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL basic[%0d]: got data=%h user=%0d last=%b, expected data=%h user=%0d last=%b",
                     i, got_q[i].data, got_q[i].user, got_q[i].last,
                     exp_q[i].data, exp_q[i].user, exp_q[i].last);
         end
      end
      checks++;
      if ({overflow, frame_err} !== 2'b00) begin
         failures++;
         $display("FAIL basic_flags: got ovf=%b ferr=%b, expected 0 0", overflow, frame_err);
      end
      end_capture();
   endtask

   task automatic test_random();
      start_test();
      stop_rand = 1'b0;
      fork
         begin
            for (int f = 0; f < 3; f++) begin
               randomize_frame();
               if (f == 0) frame_d[3] = 24'h800001;
               expect_slots(0, SLOTS - 1);
               send_frame(1'b1);
            end
            cycles(40);
            stop_rand = 1'b1;
         end
         begin
            while (!stop_rand) begin
               m_axis_tready = 1'($urandom_range(0, 1));
               cycles(1);
            end
         end
      join
      m_axis_tready = 1'b1;
      cycles(20);
      checks++;
      if (got_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL random_count: got %0d samples, expected %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL random[%0d]: got data=%h user=%0d last=%b, expected data=%h user=%0d last=%b",
                     i, got_q[i].data, got_q[i].user, got_q[i].last,
                     exp_q[i].data, exp_q[i].user, exp_q[i].last);
         end
      end
      checks++;
      if (got_q.size() < 4) begin
         failures++;
         $display("FAIL random_signed: got %0d samples, expected at least 4", got_q.size());
      end else if ($signed(got_q[3].data) != -24'sd8388607 || got_q[3].user != 3'd3) begin
         failures++;
         $display("FAIL random_signed: got %0d user=%0d, expected -8388607 user=3",
                  $signed(got_q[3].data), got_q[3].user);
      end
      checks++;
      if ({overflow, frame_err} !== 2'b00) begin
         failures++;
         $display("FAIL random_flags: got ovf=%b ferr=%b, expected 0 0", overflow, frame_err);
      end
      end_capture();
   endtask

   task automatic test_backpressure();
      start_test();
      m_axis_tready = 1'b0;
      randomize_frame();
      expect_slots(0, 3);
      saved_d = frame_d;
      send_frame(1'b1);
      randomize_frame();
      send_frame(1'b1);
      cycles(20);
      checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== saved_d[0] || m_axis_tuser !== 3'd0) begin
         failures++;
         $display("FAIL bp_hold: got valid=%b data=%h user=%0d, expected 1 %h 0",
                  m_axis_tvalid, m_axis_tdata, m_axis_tuser, saved_d[0]);
      end
      checks++;
      if (overflow !== 1'b1) begin
         failures++;
         $display("FAIL bp_overflow: got %b, expected 1", overflow);
      end
      m_axis_tready = 1'b1;
      cycles(20);
      checks++;
      if (got_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL bp_count: got %0d samples, expected %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL bp[%0d]: got data=%h user=%0d last=%b, expected data=%h user=%0d last=%b",
                     i, got_q[i].data, got_q[i].user, got_q[i].last,
                     exp_q[i].data, exp_q[i].user, exp_q[i].last);
         end
      end
      checks++;
      if (m_axis_tvalid !== 1'b0) begin
         failures++;
         $display("FAIL bp_drained: got valid=%b, expected 0", m_axis_tvalid);
      end
      clear = 1'b1;
      cycles(1);
      clear = 1'b0;
      cycles(1);
      checks++;
      if (overflow !== 1'b0) begin
         failures++;
         $display("FAIL bp_clear: got ovf=%b, expected 0", overflow);
      end
      end_capture();
   endtask

   task automatic test_fsync_early();
      start_test();
      randomize_frame();
      expect_slots(0, 1);
      send_slot_bits(frame_d[0], 1'b1, 0, SLOT_BITS - 1);
      send_slot_bits(frame_d[1], 1'b0, 0, SLOT_BITS - 1);
      send_slot_bits(frame_d[2], 1'b0, 0, 9);
      randomize_frame();
      expect_slots(0, SLOTS - 1);
      send_frame(1'b1);
      cycles(20);
      checks++;
      if (frame_err !== 1'b1) begin
         failures++;
         $display("FAIL early_ferr: got %b, expected 1", frame_err);
      end
      checks++;
      if (got_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL early_count: got %0d samples, expected %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL early[%0d]: got data=%h user=%0d last=%b, expected data=%h user=%0d last=%b",
                     i, got_q[i].data, got_q[i].user, got_q[i].last,
                     exp_q[i].data, exp_q[i].user, exp_q[i].last);
         end
      end
      clear = 1'b1;
      cycles(1);
      clear = 1'b0;
      cycles(1);
      checks++;
      if (frame_err !== 1'b0) begin
         failures++;
         $display("FAIL early_clear: got ferr=%b, expected 0", frame_err);
      end
      end_capture();
   endtask

   task automatic test_missing_fsync();
      start_test();
      randomize_frame();
      expect_slots(0, SLOTS - 1);
      send_frame(1'b1);
      randomize_frame();
      send_frame(1'b0);
      cycles(20);
      checks++;
      if (frame_err !== 1'b1) begin
         failures++;
         $display("FAIL missing_ferr: got %b, expected 1", frame_err);
      end
      clear = 1'b1;
      cycles(1);
      clear = 1'b0;
      randomize_frame();
      expect_slots(0, SLOTS - 1);
      send_frame(1'b1);
      cycles(20);
      checks++;
      if (got_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL missing_count: got %0d samples, expected %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL missing[%0d]: got data=%h user=%0d last=%b, expected data=%h user=%0d last=%b",
                     i, got_q[i].data, got_q[i].user, got_q[i].last,
                     exp_q[i].data, exp_q[i].user, exp_q[i].last);
         end
      end
      checks++;
      if (frame_err !== 1'b0) begin
         failures++;
         $display("FAIL missing_ferr_after: got %b, expected 0", frame_err);
      end
      end_capture();
   endtask

   task automatic test_reset_mid();
      start_test();
      m_axis_tready = 1'b0;
      randomize_frame();
      for (int s = 0; s < 5; s++) send_slot_bits(frame_d[s], s == 0, 0, SLOT_BITS - 1);
      send_slot_bits(frame_d[5], 1'b0, 0, 9);
      checks++;
      if (m_axis_tvalid !== 1'b1 || overflow !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid_before: got valid=%b ovf=%b, expected 1 1", m_axis_tvalid, overflow);
      end
      m_axis_areset = 1'b1;
      cycles(1);
      checks++;
      if (m_axis_tvalid !== 1'b0 || overflow !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_after: got valid=%b ovf=%b, expected 0 0", m_axis_tvalid, overflow);
      end
      m_axis_areset = 1'b0;
      m_axis_tready = 1'b1;
      got_q.delete();
      send_slot_bits(frame_d[5], 1'b0, 10, SLOT_BITS - 1);
      send_slot_bits(frame_d[6], 1'b0, 0, SLOT_BITS - 1);
      send_slot_bits(frame_d[7], 1'b0, 0, SLOT_BITS - 1);
      cycles(20);
      checks++;
      if (got_q.size() != 0) begin
         failures++;
         $display("FAIL rst_mid_quiet: got %0d samples, expected 0", got_q.size());
      end
      randomize_frame();
      expect_slots(0, SLOTS - 1);
      send_frame(1'b1);
      cycles(20);
      checks++;
      if (got_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL rst_mid_count: got %0d samples, expected %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL rst_mid[%0d]: got data=%h user=%0d last=%b, expected data=%h user=%0d last=%b",
                     i, got_q[i].data, got_q[i].user, got_q[i].last,
                     exp_q[i].data, exp_q[i].user, exp_q[i].last);
         end
      end
      end_capture();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_random();
      test_backpressure();
      test_fsync_early();
      test_missing_fsync();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
